// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// shift_arbiter : two-port round-robin access to one 32-bit barrel shifter,
//                 request stage (S1) + registered result stage (S2). Rev 1.0
// ============================================================================
module shift_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_sh,
  input  logic        req0_dir,
  input  logic [31:0] req0_a,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_sh,
  input  logic        req1_dir,
  input  logic [31:0] req1_a,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_lco,
  output logic        resp_rco
);

  localparam logic [0:0] PORT0 = 1'b0;
  localparam logic [0:0] PORT1 = 1'b1;

  // Request stage
  logic        s1_valid;
  logic        s1_id;
  logic [4:0]  s1_sh;
  logic        s1_dir;
  logic [31:0] s1_a;

  // Round-robin pointer: port that wins the next tie
  logic        prio;

  logic        s2_free;
  logic        s1_move;
  logic        accept;
  logic        grant;
  logic        handshake;

  logic [4:0]  new_sh;
  logic        new_dir;
  logic [31:0] new_a;

  logic [32:0] left_ext;
  logic [32:0] right_ext;
  logic [31:0] shift_data;
  logic        shift_lco;
  logic        shift_rco;

  always_comb begin
    s2_free = !resp_valid || resp_ready;
    s1_move = s1_valid && s2_free;
    accept  = !s1_valid || s1_move;

    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = PORT1;
    end else begin
      grant = PORT0;
    end

    req0_ready = accept && (grant == PORT0) && req0_valid;
    req1_ready = accept && (grant == PORT1) && req1_valid;
    handshake  = req0_ready || req1_ready;

    if (grant == PORT1) begin
      new_sh  = req1_sh;
      new_dir = req1_dir;
      new_a   = req1_a;
    end else begin
      new_sh  = req0_sh;
      new_dir = req0_dir;
      new_a   = req0_a;
    end
  end

  // Carries come from the bit shifted just past either end of the word,
  // reported for both directions.
  always_comb begin
    left_ext   = {1'b0, s1_a} << s1_sh;
    right_ext  = {s1_a, 1'b0} >> s1_sh;
    shift_data = s1_dir ? (s1_a >> s1_sh) : (s1_a << s1_sh);
    shift_lco  = left_ext[32];
    shift_rco  = right_ext[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_sh    <= 5'd0;
      s1_dir   <= 1'b0;
      s1_a     <= 32'd0;
      prio     <= PORT0;
    end else begin
      if (accept) begin
        s1_valid <= handshake;
        if (handshake) begin
          s1_id  <= grant;
          s1_sh  <= new_sh;
          s1_dir <= new_dir;
          s1_a   <= new_a;
        end
      end
      if (handshake) begin
        prio <= !grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= 32'd0;
      resp_lco   <= 1'b0;
      resp_rco   <= 1'b0;
    end else if (s1_move) begin
      resp_valid <= 1'b1;
      resp_id    <= s1_id;
      resp_data  <= shift_data;
      resp_lco   <= shift_lco;
      resp_rco   <= shift_rco;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// Bench for shift_arbiter: directed cases plus random traffic, checked by a
// scoreboard fed from observed handshakes and drained by a response monitor.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_dir;
  logic [4:0]  req0_sh;
  logic [31:0] req0_a;
  logic        req1_valid, req1_ready, req1_dir;
  logic [4:0]  req1_sh;
  logic [31:0] req1_a;
  logic        resp_valid, resp_ready, resp_id, resp_lco, resp_rco;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sh(req0_sh),
    .req0_dir(req0_dir), .req0_a(req0_a),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sh(req1_sh),
    .req1_dir(req1_dir), .req1_a(req1_a),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_lco(resp_lco), .resp_rco(resp_rco)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        lco;
    logic        rco;
  } resp_t;

  resp_t sb[$];
  int    tests = 0;
  int    fails = 0;

  // Reference: the shift written as plain 64-bit arithmetic on the operand.
  function automatic resp_t model(logic id, logic [4:0] sh, logic dir, logic [31:0] a);
    resp_t           r;
    longint unsigned wide;
    int              n;
    wide   = 64'(a);
    n      = int'(sh);
    r.id   = id;
    r.data = dir ? 32'(wide >> n) : 32'((wide << n) & 64'hFFFF_FFFF);
    r.lco  = (n == 0) ? 1'b0 : 1'((wide << n) >> 32);
    r.rco  = (n == 0) ? 1'b0 : 1'(wide >> (n - 1));
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: push on request handshakes, pop on response handshakes.
  logic  mprio;
  logic  prev_stall;
  resp_t prev_resp;
  resp_t exp_r;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mprio      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {resp_valid, resp_id, resp_data, resp_lco, resp_rco},
            {1'b1, prev_resp});
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(sb.size()), 64'd1);
        end else begin
          exp_r = sb.pop_front();
          chk("resp", {resp_id, resp_data, resp_lco, resp_rco}, exp_r);
        end
      end
      if (req0_ready || req1_ready)
        chk("one_ready", {req0_ready, req1_ready} == 2'b11, 1'b0);
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        chk("rr_grant", req1_ready, mprio);
      if (req0_valid && req0_ready) begin
        sb.push_back(model(1'b0, req0_sh, req0_dir, req0_a));
        mprio = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1'b1, req1_sh, req1_dir, req1_a));
        mprio = 1'b0;
      end
      prev_stall = resp_valid && !resp_ready;
      prev_resp  = {resp_id, resp_data, resp_lco, resp_rco};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_hs(output logic h0, output logic h1);
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(string name);
    resp_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 50 && (sb.size() != 0 || resp_valid); i++) tick();
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic directed(string name, logic port, logic [4:0] sh, logic dir,
                          logic [31:0] a, logic [34:0] exp);
    logic h0, h1;
    resp_ready = 1'b1;
    if (port) begin
      req1_valid = 1'b1; req1_sh = sh; req1_dir = dir; req1_a = a;
    end else begin
      req0_valid = 1'b1; req0_sh = sh; req0_dir = dir; req0_a = a;
    end
    #1;
    chk({name, "_ready"}, port ? req1_ready : req0_ready, 1'b1);
    tick_hs(h0, h1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({name, "_not_early"}, resp_valid, 1'b0);
    tick();
    chk({name, "_valid"}, resp_valid, 1'b1);
    chk(name, {resp_id, resp_data, resp_lco, resp_rco}, exp);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  h0, h1;
    int    acc;
    resp_t first;

    rst = 1'b1;
    resp_ready = 1'b0;
    req0_valid = 1'b0; req0_sh = '0; req0_dir = 1'b0; req0_a = '0;
    req1_valid = 1'b0; req1_sh = '0; req1_dir = 1'b0; req1_a = '0;
    tick();
    tick();
    chk("reset_resp", {resp_valid, resp_id, resp_data, resp_lco, resp_rco}, 64'd0);
    rst = 1'b0;

    directed("left_carry", 1'b0, 5'd1, 1'b0, 32'h8000_0001, {1'b0, 32'h0000_0002, 1'b1, 1'b1});
    directed("right_carry", 1'b1, 5'd2, 1'b1, 32'h0000_0006, {1'b1, 32'h0000_0001, 1'b0, 1'b1});
    directed("zero_shift", 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});

    // Contention from reset: grants alternate starting with port 0
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_sh = 5'($urandom); req0_dir = 1'($urandom); req0_a = $urandom;
    req1_valid = 1'b1; req1_sh = 5'($urandom); req1_dir = 1'($urandom); req1_a = $urandom;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("contend_grant", {req0_ready, req1_ready}, (i % 2 == 1) ? 2'b01 : 2'b10);
      tick_hs(h0, h1);
      if (h0) begin req0_sh = 5'($urandom); req0_dir = 1'($urandom); req0_a = $urandom; end
      if (h1) begin req1_sh = 5'($urandom); req1_dir = 1'($urandom); req1_a = $urandom; end
      if (i >= 1) chk("contend_rate", resp_valid, 1'b1);
    end
    drain("contend_drain");

    // Backpressure: four port-0 requests against a stalled consumer
    resp_ready = 1'b0;
    acc = 0;
    req0_valid = 1'b1; req0_sh = 5'd3; req0_dir = 1'b0; req0_a = 32'h1111_0001;
    first = model(1'b0, 5'd3, 1'b0, 32'h1111_0001);
    for (int i = 0; i < 5; i++) begin
      tick_hs(h0, h1);
      if (h0) begin
        acc++;
        req0_a = 32'h1111_0001 + 32'(acc); req0_sh = 5'(3 + acc); req0_dir = 1'(acc);
      end
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_ready_low", req0_ready, 1'b0);
    chk("bp_first_held", {resp_valid, resp_data}, {1'b1, first.data});
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      tick_hs(h0, h1);
      if (h0) begin
        acc++;
        req0_a = 32'h1111_0001 + 32'(acc); req0_sh = 5'(3 + acc); req0_dir = 1'(acc);
        if (acc == 4) req0_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", 64'(acc), 64'd4);
    drain("bp_drain");

    // Reset with both stages full; prio was left pointing at port 1
    resp_ready = 1'b0;
    acc = 0;
    req0_valid = 1'b1; req0_sh = 5'd7; req0_dir = 1'b1; req0_a = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && acc < 2; i++) begin
      tick_hs(h0, h1);
      if (h0) begin acc++; req0_a = 32'hCAFE_F00D; end
    end
    req0_valid = 1'b0;
    chk("rf_full", {resp_valid, 64'(acc)}, {1'b1, 64'd2});
    do_reset();
    chk("rf_cleared", {resp_valid, resp_data}, 33'd0);
    req0_valid = 1'b1; req0_sh = 5'd1; req0_dir = 1'b0; req0_a = 32'h0000_0100;
    req1_valid = 1'b1; req1_sh = 5'd1; req1_dir = 1'b1; req1_a = 32'h0000_0100;
    #1;
    chk("rf_prio", {req0_ready, req1_ready}, 2'b10);
    resp_ready = 1'b1;
    tick_hs(h0, h1);
    req0_valid = 1'b0;
    tick_hs(h0, h1);
    drain("rf_drain");

    // Random traffic on both ports with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || h0) begin
        req0_valid = ($urandom_range(3) != 0);
        req0_sh = 5'($urandom); req0_dir = 1'($urandom); req0_a = $urandom;
      end
      if (!req1_valid || h1) begin
        req1_valid = ($urandom_range(3) != 0);
        req1_sh = 5'($urandom); req1_dir = 1'($urandom); req1_a = $urandom;
      end
      resp_ready = ($urandom_range(3) != 0);
      tick_hs(h0, h1);
    end
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
